rename_regfile_mp: RTL and testbench

Parametrised successor to the single-issue architectural register file with rename tags ("nicks").
- Holds NREG architectural registers, each with data and a rename tag. Tag 0 means the committed value is current.
- Serves NRD source operands per dispatch and registers them into a one-deep dispatch output stage with a valid/ready handshake.
- While an operand is held in that stage, it snoops the ROB commit bus so it never goes stale.
- Sits between instruction decode (IND) and dispatch (DP); ROB drives the rename and commit ports.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_operand_slot.sv | 65 ++++++
 rtl/rename_regfile_mp.sv | 106 ++++++++++
 tb/tb_rename_regfile_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and types for the renamed architectural register file.
package rf_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_NREG  = 32;
   localparam int RF_TAG_W = 4;

   localparam logic [RF_TAG_W-1:0] NO_TAG = '0;

   typedef logic [RF_TAG_W-1:0] rf_tag_t;
   typedef logic [RF_XLEN-1:0]  rf_data_t;

   typedef struct packed {
      rf_data_t dt;
      rf_tag_t  nick;
   } rf_operand_t;

endpackage

// File: rtl/rf_operand_slot.sv
// One dispatch operand: register lookup, optional commit bypass (RENAME_RF_BYPASS_EN),
// held output register and commit-bus snoop while the operand waits in the stage.
module rf_operand_slot
   import rf_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREG  = RF_NREG,
   parameter int TAG_W = RF_TAG_W,
   localparam int RW   = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             load,
   input  logic             snoop_en,
   input  logic [RW-1:0]    regnm,
   input  logic [XLEN-1:0]  reg_dt [NREG],
   input  logic [TAG_W-1:0] reg_nick [NREG],
   input  logic             rob_en,
`ifdef RENAME_RF_BYPASS_EN
   input  logic [RW-1:0]    rob_rd_regnm,
`endif
   input  logic [XLEN-1:0]  rob_rd_dt,
   input  logic [TAG_W-1:0] rob_rd_nick,
   output logic [XLEN-1:0]  dt,
   output logic [TAG_W-1:0] nick
);

   logic [XLEN-1:0]  cap_dt;
   logic [TAG_W-1:0] cap_nick;

   // Register 0 reads as a committed zero regardless of array contents.
   always_comb begin
      cap_dt   = '0;
      cap_nick = TAG_W'(NO_TAG);
      if (regnm != '0) begin
         cap_dt   = reg_dt[regnm];
         cap_nick = reg_nick[regnm];
      end
`ifdef RENAME_RF_BYPASS_EN
      if (regnm != '0 && rob_en && regnm == rob_rd_regnm &&
          rob_rd_nick != TAG_W'(NO_TAG) && reg_nick[regnm] == rob_rd_nick) begin
         cap_dt   = rob_rd_dt;
         cap_nick = TAG_W'(NO_TAG);
      end
`endif
   end

   // A held operand waiting on a tag picks up the matching commit so it never goes stale.
   always_ff @(posedge clk) begin
      if (rst) begin
         dt   <= '0;
         nick <= TAG_W'(NO_TAG);
      end else if (rdy) begin
         if (load) begin
            dt   <= cap_dt;
            nick <= cap_nick;
         end else if (snoop_en && rob_en && nick != TAG_W'(NO_TAG) && nick == rob_rd_nick) begin
            dt   <= rob_rd_dt;
            nick <= TAG_W'(NO_TAG);
         end
      end
   end

endmodule

// File: rtl/rename_regfile_mp.sv
// Multi-operand architectural register file with rename tags and a one-deep dispatch stage.
// Optional same-cycle commit bypass on read is enabled by defining RENAME_RF_BYPASS_EN.
module rename_regfile_mp
   import rf_pkg::*;
#(
   parameter int XLEN      = RF_XLEN,
   parameter int NREG      = RF_NREG,
   parameter int TAG_W     = RF_TAG_W,
   parameter int NRD       = 2,
   parameter int PAYLOAD_W = 64,
   localparam int RW       = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 clr,
   input  logic                 iIND_en,
   output logic                 oIND_rdy,
   input  logic [NRD*RW-1:0]    iIND_regnm,
   input  logic [PAYLOAD_W-1:0] iIND_payload,
   output logic                 oDP_en,
   input  logic                 iDP_rdy,
   output logic [NRD*XLEN-1:0]  oDP_dt,
   output logic [NRD*TAG_W-1:0] oDP_nick,
   output logic [PAYLOAD_W-1:0] oDP_payload,
   input  logic                 iROB_nick_en,
   input  logic [RW-1:0]        iROB_nick_regnm,
   input  logic [TAG_W-1:0]     iROB_nick,
   input  logic                 iROB_en,
   input  logic [RW-1:0]        iROB_rd_regnm,
   input  logic [XLEN-1:0]      iROB_rd_dt,
   input  logic [TAG_W-1:0]     iROB_rd_nick
);

   logic [XLEN-1:0]  reg_dt   [NREG];
   logic [TAG_W-1:0] reg_nick [NREG];
   logic             accept;
   logic             commit_hit;

   assign oIND_rdy   = rdy & ~clr & (~oDP_en | iDP_rdy);
   assign accept     = iIND_en & oIND_rdy;
   assign commit_hit = iROB_en && iROB_rd_nick != TAG_W'(NO_TAG) &&
                       reg_nick[iROB_rd_regnm] == iROB_rd_nick;

   // Commit data always lands; for the tag, flush beats rename, which beats commit-clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            reg_dt[i]   <= '0;
            reg_nick[i] <= TAG_W'(NO_TAG);
         end
      end else if (rdy) begin
         if (iROB_en && iROB_rd_regnm != '0)
            reg_dt[iROB_rd_regnm] <= iROB_rd_dt;
         if (clr) begin
            for (int i = 0; i < NREG; i++)
               reg_nick[i] <= TAG_W'(NO_TAG);
         end else begin
            if (commit_hit && iROB_rd_regnm != '0)
               reg_nick[iROB_rd_regnm] <= TAG_W'(NO_TAG);
            if (iROB_nick_en && iROB_nick_regnm != '0)
               reg_nick[iROB_nick_regnm] <= iROB_nick;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         oDP_en      <= 1'b0;
         oDP_payload <= '0;
      end else if (rdy) begin
         if (accept) begin
            oDP_en      <= 1'b1;
            oDP_payload <= iIND_payload;
         end else if (clr || iDP_rdy) begin
            oDP_en <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_slot
      rf_operand_slot #(
         .XLEN  (XLEN),
         .NREG  (NREG),
         .TAG_W (TAG_W)
      ) u_slot (
         .clk          (clk),
         .rst          (rst),
         .rdy          (rdy),
         .load         (accept),
         .snoop_en     (oDP_en & ~accept),
         .regnm        (iIND_regnm[k*RW +: RW]),
         .reg_dt       (reg_dt),
         .reg_nick     (reg_nick),
         .rob_en       (iROB_en),
`ifdef RENAME_RF_BYPASS_EN
         .rob_rd_regnm (iROB_rd_regnm),
`endif
         .rob_rd_dt    (iROB_rd_dt),
         .rob_rd_nick  (iROB_rd_nick),
         .dt           (oDP_dt[k*XLEN +: XLEN]),
         .nick         (oDP_nick[k*TAG_W +: TAG_W])
      );
   end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Self-checking bench: directed scenarios then random traffic against a behavioural model.
module tb_rename_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int TAG_W = 4;
   localparam int NRD = 2;
   localparam int PW = 64;
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst, rdy, clr, iIND_en, oIND_rdy, oDP_en, iDP_rdy;
   logic [NRD*RW-1:0]    iIND_regnm;
   logic [PW-1:0]        iIND_payload, oDP_payload;
   logic [NRD*XLEN-1:0]  oDP_dt;
   logic [NRD*TAG_W-1:0] oDP_nick;
   logic                 iROB_nick_en, iROB_en;
   logic [RW-1:0]        iROB_nick_regnm, iROB_rd_regnm;
   logic [TAG_W-1:0]     iROB_nick, iROB_rd_nick;
   logic [XLEN-1:0]      iROB_rd_dt;

   int total = 0;
   int bad = 0;

   logic [XLEN-1:0]  m_dt [NREG];
   logic [TAG_W-1:0] m_nick [NREG];
   logic             m_en = 1'b0;
   logic [XLEN-1:0]  m_op_dt [NRD];
   logic [TAG_W-1:0] m_op_nick [NRD];
   logic [PW-1:0]    m_pay = '0;

   always #5 clk = ~clk;

   rename_regfile_mp dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
      .iIND_en(iIND_en), .oIND_rdy(oIND_rdy), .iIND_regnm(iIND_regnm), .iIND_payload(iIND_payload),
      .oDP_en(oDP_en), .iDP_rdy(iDP_rdy), .oDP_dt(oDP_dt), .oDP_nick(oDP_nick), .oDP_payload(oDP_payload),
      .iROB_nick_en(iROB_nick_en), .iROB_nick_regnm(iROB_nick_regnm), .iROB_nick(iROB_nick),
      .iROB_en(iROB_en), .iROB_rd_regnm(iROB_rd_regnm), .iROB_rd_dt(iROB_rd_dt), .iROB_rd_nick(iROB_rd_nick)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic setIdle();
      rst = 1'b0; rdy = 1'b1; clr = 1'b0; iIND_en = 1'b0; iDP_rdy = 1'b1;
      iIND_regnm = '0; iIND_payload = '0;
      iROB_nick_en = 1'b0; iROB_nick_regnm = '0; iROB_nick = '0;
      iROB_en = 1'b0; iROB_rd_regnm = '0; iROB_rd_dt = '0; iROB_rd_nick = '0;
   endtask

   // Register-file semantics applied to the current inputs, all reads taken from the old state.
   task automatic modelStep();
      logic             acc;
      logic             hit;
      logic [RW-1:0]    idx;
      logic [XLEN-1:0]  cd;
      logic [TAG_W-1:0] cn;
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin m_dt[i] = '0; m_nick[i] = '0; end
         for (int k = 0; k < NRD; k++) begin m_op_dt[k] = '0; m_op_nick[k] = '0; end
         m_en = 1'b0; m_pay = '0;
         return;
      end
      if (!rdy) return;
      acc = iIND_en && !clr && (!m_en || iDP_rdy);
      hit = iROB_en && iROB_rd_nick != 0 && m_nick[iROB_rd_regnm] == iROB_rd_nick;
      for (int k = 0; k < NRD; k++) begin
         idx = iIND_regnm[k*RW +: RW];
         cd = (idx == 0) ? '0 : m_dt[idx];
         cn = (idx == 0) ? '0 : m_nick[idx];
`ifdef RENAME_RF_BYPASS_EN
         if (idx != 0 && idx == iROB_rd_regnm && hit) begin cd = iROB_rd_dt; cn = '0; end
`endif
         if (acc) begin
            m_op_dt[k] = cd; m_op_nick[k] = cn;
         end else if (m_en && iROB_en && iROB_rd_nick != 0 && m_op_nick[k] == iROB_rd_nick) begin
            m_op_dt[k] = iROB_rd_dt; m_op_nick[k] = '0;
         end
      end
      if (iROB_en && iROB_rd_regnm != 0) m_dt[iROB_rd_regnm] = iROB_rd_dt;
      if (clr) begin
         for (int i = 0; i < NREG; i++) m_nick[i] = '0;
      end else begin
         if (hit && iROB_rd_regnm != 0) m_nick[iROB_rd_regnm] = '0;
         if (iROB_nick_en && iROB_nick_regnm != 0) m_nick[iROB_nick_regnm] = iROB_nick;
      end
      if (acc) begin m_en = 1'b1; m_pay = iIND_payload; end
      else if (clr || iDP_rdy) m_en = 1'b0;
   endtask

   task automatic applyStimulus();
      #1;
      checkOutput("ind_rdy", oIND_rdy, rdy && !clr && (!m_en || iDP_rdy));
      modelStep();
      @(posedge clk);
      #1;
      checkOutput("dp_en", oDP_en, m_en);
      checkOutput("dp_payload", oDP_payload, m_pay);
      for (int k = 0; k < NRD; k++) begin
         checkOutput($sformatf("dt%0d", k), oDP_dt[k*XLEN +: XLEN], m_op_dt[k]);
         checkOutput($sformatf("nick%0d", k), oDP_nick[k*TAG_W +: TAG_W], m_op_nick[k]);
      end
      @(negedge clk);
   endtask

   task automatic doRename(input int r, input int t);
      setIdle(); iROB_nick_en = 1'b1; iROB_nick_regnm = RW'(r); iROB_nick = TAG_W'(t);
      applyStimulus();
   endtask

   task automatic doDispatch(input int a, input int b, input logic dp_rdy);
      iIND_en = 1'b1; iIND_regnm = {RW'(b), RW'(a)};
      iIND_payload = {$urandom, $urandom}; iDP_rdy = dp_rdy;
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) begin m_dt[i] = '0; m_nick[i] = '0; end
      for (int k = 0; k < NRD; k++) begin m_op_dt[k] = '0; m_op_nick[k] = '0; end
      setIdle(); rst = 1'b1;
      @(negedge clk);
      applyStimulus();

      setIdle(); iROB_en = 1'b1; iROB_rd_regnm = 5; iROB_rd_dt = 32'h1234;
      applyStimulus();
      setIdle(); doDispatch(5, 0, 1'b1);
      applyStimulus();
      checkOutput("t1_dt", oDP_dt[XLEN-1:0], 32'h1234);
      checkOutput("t1_en", oDP_en, 1'b1);
      setIdle(); applyStimulus();

      doRename(3, 7);
      setIdle(); doDispatch(3, 0, 1'b1);
      iROB_en = 1'b1; iROB_rd_regnm = 3; iROB_rd_dt = 32'hAA; iROB_rd_nick = 7;
      applyStimulus();
`ifdef RENAME_RF_BYPASS_EN
      checkOutput("t2_nick", oDP_nick[TAG_W-1:0], 4'd0);
      checkOutput("t2_dt", oDP_dt[XLEN-1:0], 32'hAA);
`else
      checkOutput("t2_nick", oDP_nick[TAG_W-1:0], 4'd7);
`endif

      doRename(4, 4);
      setIdle(); doDispatch(4, 0, 1'b0);
      applyStimulus();
      setIdle(); doDispatch(1, 1, 1'b0);
      iROB_en = 1'b1; iROB_rd_regnm = 4; iROB_rd_dt = 32'h55; iROB_rd_nick = 4;
      applyStimulus();
      checkOutput("t3_nick", oDP_nick[TAG_W-1:0], 4'd0);
      checkOutput("t3_dt", oDP_dt[XLEN-1:0], 32'h55);
      setIdle(); iDP_rdy = 1'b0; applyStimulus();
      setIdle(); applyStimulus();

      doRename(2, 3);
      doRename(2, 9);
      setIdle(); iROB_en = 1'b1; iROB_rd_regnm = 2; iROB_rd_dt = 32'h77; iROB_rd_nick = 3;
      applyStimulus();
      setIdle(); doDispatch(2, 2, 1'b1);
      applyStimulus();
      checkOutput("t4_nick", oDP_nick[TAG_W-1:0], 4'd9);
      checkOutput("t4_dt", oDP_dt[XLEN-1:0], 32'h77);

      for (int r = 1; r <= 4; r++) doRename(r, r);
      setIdle(); doDispatch(1, 2, 1'b0);
      applyStimulus();
      setIdle(); clr = 1'b1; iIND_en = 1'b1; iDP_rdy = 1'b0;
      iROB_nick_en = 1'b1; iROB_nick_regnm = 5; iROB_nick = 6;
      applyStimulus();
      checkOutput("t5_en", oDP_en, 1'b0);
      setIdle(); doDispatch(5, 3, 1'b1);
      applyStimulus();
      checkOutput("t5_nick5", oDP_nick[TAG_W-1:0], 4'd0);
      checkOutput("t5_nick3", oDP_nick[2*TAG_W-1:TAG_W], 4'd0);

      setIdle(); iROB_nick_en = 1'b1; iROB_nick_regnm = 0; iROB_nick = 5;
      iROB_en = 1'b1; iROB_rd_regnm = 0; iROB_rd_dt = 32'hFF;
      applyStimulus();
      setIdle(); doDispatch(0, 0, 1'b0);
      applyStimulus();
      checkOutput("t6_dt", oDP_dt, '0);
      checkOutput("t6_nick", oDP_nick, '0);
      setIdle(); iDP_rdy = 1'b0; applyStimulus();
      setIdle(); rst = 1'b1; iDP_rdy = 1'b0; applyStimulus();
      checkOutput("t6_rst_en", oDP_en, 1'b0);
      checkOutput("t6_rst_pay", oDP_payload, '0);

      for (int n = 0; n < 3000; n++) begin
         int rd;
         setIdle();
         rst = ($urandom_range(0, 299) == 0);
         rdy = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 39) == 0);
         iDP_rdy = $urandom_range(0, 1);
         iIND_en = $urandom_range(0, 1);
         iIND_regnm = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
         iIND_payload = {$urandom, $urandom};
         iROB_nick_en = $urandom_range(0, 1);
         iROB_nick_regnm = RW'($urandom_range(0, 7));
         iROB_nick = TAG_W'($urandom_range(1, 15));
         iROB_en = $urandom_range(0, 1);
         rd = $urandom_range(0, 7);
         iROB_rd_regnm = RW'(rd);
         iROB_rd_dt = $urandom;
         if ($urandom_range(0, 2) != 0) iROB_rd_nick = m_nick[rd];
         else if ($urandom_range(0, 1) == 0) iROB_rd_nick = m_op_nick[$urandom_range(0, NRD-1)];
         else iROB_rd_nick = TAG_W'($urandom_range(0, 15));
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
